inst_sram_responder: RTL

Responder end of the instruction SRAM interface that the fetch stage drives. It decodes en/wen/addr/wdata and returns read data on inst_sram_rdata exactly one cycle after an accepted access. It is backed by a word-organised RAM with byte-lane write enables. A back-door load port preloads the boot image, and sticky error and access counters support debug.

---
 rtl/mycpu_mem_pkg.sv | 29 ++
 rtl/sram_bytewrite_ram.sv | 42 ++++
 rtl/inst_sram_responder.sv | 74 +++++++
 3 files changed

// File: rtl/mycpu_mem_pkg.sv
// Shared memory-map constants and the instruction-address decode used by the SRAM responder.
package mycpu_mem_pkg;

    localparam logic [31:0] BASE_PA_DEFAULT = 32'h1fc00000;
    localparam logic [31:0] KSEG_MASK       = 32'h1fffffff;

    typedef struct packed {
        logic        in_range;
        logic [29:0] idx;
    } addr_dec_t;

    // Strip the kseg bits, rebase to word 0, and bound-check. An address below
    // base underflows to a large offset and therefore lands out of range.
    function automatic addr_dec_t addr_decode(input logic [31:0] addr,
                                              input int unsigned addr_w,
                                              input logic [31:0] base);
        addr_dec_t   dec;
        logic [31:0] pa;
        logic [31:0] off;
        logic [32:0] lim;
        pa           = addr & KSEG_MASK;
        off          = pa - base;
        lim          = 33'd4 << addr_w;
        dec.in_range = {1'b0, off} < lim;
        dec.idx      = off[31:2];
        return dec;
    endfunction

endpackage

// File: rtl/sram_bytewrite_ram.sv
// Word-organised RAM with byte-lane writes, a full-word load port that wins
// over the main port, and a read-first registered output.
module sram_bytewrite_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              clr,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_idx,
    input  logic [31:0]       load_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Output register holds whenever neither an access nor a clear is requested.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: address decode, load/write arbitration,
// sticky out-of-range flag and saturating access counters around the RAM.
module inst_sram_responder
    import mycpu_mem_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE_PA = BASE_PA_DEFAULT,
    parameter int          CNT_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              err_oob,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    addr_dec_t          dec;
    logic [ADDR_W-1:0]  idx;
    logic               acc_ok;
    logic               acc_oob;
    logic               is_wr;
    logic [3:0]         ram_we;
    logic               unused_idx_bits;

    assign dec             = addr_decode(inst_sram_addr, ADDR_W, BASE_PA);
    assign idx             = dec.idx[ADDR_W-1:0];
    assign unused_idx_bits = ^dec.idx[29:ADDR_W];
    assign acc_ok          = inst_sram_en & dec.in_range;
    assign acc_oob         = inst_sram_en & ~dec.in_range;
    assign is_wr           = |inst_sram_wen;
    // A concurrent load owns the array this cycle, so the write is dropped.
    assign ram_we          = (acc_ok && !load_en) ? inst_sram_wen : 4'b0000;

    sram_bytewrite_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .resetn    (resetn),
        .en        (acc_ok),
        .clr       (acc_oob),
        .we        (ram_we),
        .idx       (idx),
        .wdata     (inst_sram_wdata),
        .rdata     (inst_sram_rdata),
        .load_en   (load_en),
        .load_idx  (load_addr),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_oob <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            if (acc_oob) err_oob <= 1'b1;
            if (acc_ok && !is_wr && rd_cnt != CNT_MAX)
                rd_cnt <= rd_cnt + CNT_W'(1);
            if (acc_ok && is_wr && !load_en && wr_cnt != CNT_MAX)
                wr_cnt <= wr_cnt + CNT_W'(1);
        end
    end

endmodule
